// File: rtl/stage4_memory_writeback_unit.sv
// Memory/writeback stage: turns a stage3 instruction into one writeback record,
// waiting for the memory response on loads and formatting the selected lane.
module stage4_memory_writeback_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned FLEN = 32
) (
  input  logic                                    clock_i,
  input  logic                                    reset_i,
  input  logic                                    valid_i,
  output logic                                    ready_o,
  input  logic [15:0]                             encoding_i,
  input  logic [2:0]                              func3_i,
  input  logic [4:0]                              fdest_i,
  input  logic [2:0]                              addr_lsb_i,
  input  logic [XLEN-1:0]                         stage3_result_i,
  input  logic                                    mem_valid_i,
  input  logic [63:0]                             mem_data_i,
  input  logic                                    wb_ready_i,
  output logic                                    wb_valid_o,
  output logic                                    writeback_flag_o,
  output logic                                    writeback_fp_o,
  output logic [4:0]                              writeback_dest_o,
  output logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0] writeback_value_o,
  output logic                                    exception_o
);

  localparam int unsigned VW = (XLEN > FLEN) ? XLEN : FLEN;

  // Instruction classes arrive one-hot; any other pattern is treated as unknown.
  typedef enum logic [15:0] {
    ENC_LUI       = 16'h0001,
    ENC_AUIPC     = 16'h0002,
    ENC_JAL       = 16'h0004,
    ENC_JALR      = 16'h0008,
    ENC_BRANCH    = 16'h0010,
    ENC_LOAD      = 16'h0020,
    ENC_STORE     = 16'h0040,
    ENC_ARITH_IMM = 16'h0080,
    ENC_ARITH_REG = 16'h0100,
    ENC_FLOAD     = 16'h0200,
    ENC_FSTORE    = 16'h0400,
    ENC_FARITH    = 16'h0800,
    ENC_FMADD     = 16'h1000,
    ENC_FMSUB     = 16'h2000,
    ENC_FNMSUB    = 16'h4000,
    ENC_FNMADD    = 16'h8000
  } enc_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_OUT
  } state_e;

  state_e          state_q;
  logic            wb_valid_q;
  logic            wb_flag_q;
  logic            wb_fp_q;
  logic            wb_exc_q;
  logic [4:0]      wb_dest_q;
  logic [VW-1:0]   wb_value_q;
  logic [2:0]      ld_func3_q;
  logic [2:0]      ld_lsb_q;
  logic [4:0]      ld_dest_q;
  logic            ld_fp_q;

  logic            accept;
  logic            aligned;
  logic            int_legal;
  logic            fp_legal;
  logic            dec_load;
  logic            dec_ld_fp;
  logic            dec_flag;
  logic            dec_fp;
  logic            dec_exc;
  logic [VW-1:0]   dec_value;

  logic [63:0]     lane;
  logic [XLEN-1:0] int_val;
  logic [FLEN-1:0] fp_val;
  logic [VW-1:0]   fmt_value;

  assign ready_o = (state_q == S_IDLE) || ((state_q == S_OUT) && wb_ready_i);
  assign accept  = valid_i && ready_o;

  // Access size is func3[1:0]; natural alignment per size.
  always_comb begin
    aligned = 1'b1;
    case (func3_i[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lsb_i[0];
      2'b10:   aligned = (addr_lsb_i[1:0] == 2'b00);
      default: aligned = (addr_lsb_i == 3'b000);
    endcase
  end

  always_comb begin
    int_legal = 1'b0;
    case (func3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: int_legal = 1'b1;
      3'b011, 3'b110:                         int_legal = (XLEN == 64);
      default:                                int_legal = 1'b0;
    endcase
  end

  always_comb begin
    fp_legal = 1'b0;
    case (func3_i)
      3'b010:  fp_legal = 1'b1;
      3'b011:  fp_legal = (FLEN == 64);
      default: fp_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_load  = 1'b0;
    dec_ld_fp = 1'b0;
    dec_flag  = 1'b0;
    dec_fp    = 1'b0;
    dec_exc   = 1'b0;
    dec_value = '0;
    case (encoding_i)
      ENC_LUI, ENC_AUIPC, ENC_JAL, ENC_JALR, ENC_ARITH_IMM, ENC_ARITH_REG: begin
        dec_flag  = (fdest_i != 5'd0);
        dec_value = VW'(stage3_result_i);
      end
      ENC_FARITH, ENC_FMADD, ENC_FMSUB, ENC_FNMSUB, ENC_FNMADD: begin
        dec_flag  = 1'b1;
        dec_fp    = 1'b1;
        dec_value = VW'(stage3_result_i);
      end
      ENC_LOAD: begin
        dec_load = int_legal && aligned;
        dec_exc  = !(int_legal && aligned);
      end
      ENC_FLOAD: begin
        dec_ld_fp = 1'b1;
        dec_load  = fp_legal && aligned;
        dec_exc   = !(fp_legal && aligned);
      end
      default: ;
    endcase
  end

  // Lane is shifted down to bit 0 so every size extracts from the low bits.
  always_comb begin
    lane = mem_data_i >> {ld_lsb_q, 3'b000};
    case (ld_func3_q)
      3'b000:  int_val = XLEN'($signed(lane[7:0]));
      3'b100:  int_val = XLEN'(lane[7:0]);
      3'b001:  int_val = XLEN'($signed(lane[15:0]));
      3'b101:  int_val = XLEN'(lane[15:0]);
      3'b010:  int_val = XLEN'($signed(lane[31:0]));
      3'b110:  int_val = XLEN'(lane[31:0]);
      default: int_val = XLEN'(lane);
    endcase
    // NaN-boxing collapses to the plain word when FLEN is 32.
    fp_val    = ld_func3_q[0] ? FLEN'(lane) : FLEN'({32'hFFFF_FFFF, lane[31:0]});
    fmt_value = ld_fp_q ? VW'(fp_val) : VW'(int_val);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      wb_valid_q <= 1'b0;
      wb_flag_q  <= 1'b0;
      wb_fp_q    <= 1'b0;
      wb_exc_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_value_q <= '0;
      ld_func3_q <= '0;
      ld_lsb_q   <= '0;
      ld_dest_q  <= '0;
      ld_fp_q    <= 1'b0;
    end else if (accept) begin
      if (dec_load) begin
        state_q    <= S_WAIT_MEM;
        wb_valid_q <= 1'b0;
        wb_flag_q  <= 1'b0;
        wb_exc_q   <= 1'b0;
        ld_func3_q <= func3_i;
        ld_lsb_q   <= addr_lsb_i;
        ld_dest_q  <= fdest_i;
        ld_fp_q    <= dec_ld_fp;
      end else begin
        state_q    <= S_OUT;
        wb_valid_q <= 1'b1;
        wb_flag_q  <= dec_flag;
        wb_fp_q    <= dec_fp;
        wb_exc_q   <= dec_exc;
        wb_dest_q  <= fdest_i;
        wb_value_q <= dec_value;
      end
    end else begin
      case (state_q)
        S_WAIT_MEM: begin
          if (mem_valid_i) begin
            state_q    <= S_OUT;
            wb_valid_q <= 1'b1;
            wb_flag_q  <= ld_fp_q || (ld_dest_q != 5'd0);
            wb_fp_q    <= ld_fp_q;
            wb_exc_q   <= 1'b0;
            wb_dest_q  <= ld_dest_q;
            wb_value_q <= fmt_value;
          end
        end
        S_OUT: begin
          if (wb_ready_i) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
            wb_flag_q  <= 1'b0;
            wb_exc_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_valid_o        = wb_valid_q;
  assign writeback_flag_o  = wb_flag_q;
  assign writeback_fp_o    = wb_fp_q;
  assign writeback_dest_o  = wb_dest_q;
  assign writeback_value_o = wb_value_q;
  assign exception_o       = wb_exc_q;

endmodule

// File: tb/tb_stage4_memory_writeback_unit.sv
// Scoreboard bench: a 32/32 and a 64/64 instance share data inputs; drivers push
// expected records, per-instance monitors compare every presented record.
module tb_stage4_memory_writeback_unit;

  localparam logic [15:0] E_LUI       = 16'h0001;
  localparam logic [15:0] E_BRANCH    = 16'h0010;
  localparam logic [15:0] E_LOAD      = 16'h0020;
  localparam logic [15:0] E_STORE     = 16'h0040;
  localparam logic [15:0] E_ARITH_IMM = 16'h0080;
  localparam logic [15:0] E_ARITH_REG = 16'h0100;
  localparam logic [15:0] E_FLOAD     = 16'h0200;
  localparam logic [15:0] E_FARITH    = 16'h0800;
  localparam logic [15:0] E_FMADD     = 16'h1000;

  typedef struct packed {
    logic        flag;
    logic        fp;
    logic        exc;
    logic [4:0]  dest;
    logic [63:0] value;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_a, valid_b, mem_valid_a, mem_valid_b, wb_ready;
  logic [15:0] enc;
  logic [2:0]  f3;
  logic [4:0]  dest;
  logic [2:0]  lsb;
  logic [63:0] result;
  logic [63:0] mem_data;

  logic        a_ready, a_wbv, a_flag, a_fp, a_exc;
  logic [4:0]  a_dest;
  logic [31:0] a_value;
  logic        b_ready, b_wbv, b_flag, b_fp, b_exc;
  logic [4:0]  b_dest;
  logic [63:0] b_value;

  int checks = 0;
  int errors = 0;
  rec_t q_a[$];
  rec_t q_b[$];

  always #5 clk = ~clk;

  stage4_memory_writeback_unit #(.XLEN(32), .FLEN(32)) dut_a (
    .clock_i(clk), .reset_i(rst_n), .valid_i(valid_a), .ready_o(a_ready),
    .encoding_i(enc), .func3_i(f3), .fdest_i(dest), .addr_lsb_i(lsb),
    .stage3_result_i(result[31:0]), .mem_valid_i(mem_valid_a), .mem_data_i(mem_data),
    .wb_ready_i(wb_ready), .wb_valid_o(a_wbv), .writeback_flag_o(a_flag),
    .writeback_fp_o(a_fp), .writeback_dest_o(a_dest), .writeback_value_o(a_value),
    .exception_o(a_exc)
  );

  stage4_memory_writeback_unit #(.XLEN(64), .FLEN(64)) dut_b (
    .clock_i(clk), .reset_i(rst_n), .valid_i(valid_b), .ready_o(b_ready),
    .encoding_i(enc), .func3_i(f3), .fdest_i(dest), .addr_lsb_i(lsb),
    .stage3_result_i(result), .mem_valid_i(mem_valid_b), .mem_data_i(mem_data),
    .wb_ready_i(wb_ready), .wb_valid_o(b_wbv), .writeback_flag_o(b_flag),
    .writeback_fp_o(b_fp), .writeback_dest_o(b_dest), .writeback_value_o(b_value),
    .exception_o(b_exc)
  );

  function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic rec_t mk(input logic fl, input logic fp, input logic ex,
                              input logic [4:0] d, input logic [63:0] v);
    rec_t r;
    r.flag  = fl;
    r.fp    = fp;
    r.exc   = ex;
    r.dest  = d;
    r.value = v;
    return r;
  endfunction

  always @(negedge clk) begin
    if (a_wbv) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_record: actual=record dest %0d value %h required=no record", a_dest, a_value);
      end else begin
        chk("a_record", 80'({a_flag, a_fp, a_exc, a_dest, 32'h0, a_value}), 80'(q_a[0]));
        if (wb_ready) void'(q_a.pop_front());
      end
    end else begin
      chk("a_idle_flag_exc", 80'({a_flag, a_exc}), 80'(0));
    end
  end

  always @(negedge clk) begin
    if (b_wbv) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_record: actual=record dest %0d value %h required=no record", b_dest, b_value);
      end else begin
        chk("b_record", 80'({b_flag, b_fp, b_exc, b_dest, b_value}), 80'(q_b[0]));
        if (wb_ready) void'(q_b.pop_front());
      end
    end else begin
      chk("b_idle_flag_exc", 80'({b_flag, b_exc}), 80'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [15:0] e, input logic [2:0] fn,
                      input logic [4:0] d, input logic [2:0] l, input logic [63:0] r);
    logic rdy;
    enc = e; f3 = fn; dest = d; lsb = l; result = r;
    if (sel == 0) valid_a = 1'b1; else valid_b = 1'b1;
    rdy = 1'b0;
    for (int i = 0; i < 50 && !rdy; i++) begin
      @(negedge clk);
      rdy = (sel == 0) ? a_ready : b_ready;
    end
    if (!rdy) chk("send_ready_timeout", 80'(rdy), 80'(1));
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic expect_next(input int sel, input string name);
    @(negedge clk);
    chk(name, 80'((sel == 0) ? a_wbv : b_wbv), 80'(1));
    tick();
  endtask

  task automatic op(input int sel, input logic [15:0] e, input logic [2:0] fn,
                    input logic [4:0] d, input logic [2:0] l, input logic [63:0] r, input rec_t x);
    if (sel == 0) q_a.push_back(x); else q_b.push_back(x);
    send(sel, e, fn, d, l, r);
    expect_next(sel, "op_record_next_cycle");
  endtask

  task automatic ld(input int sel, input logic [15:0] e, input logic [2:0] fn,
                    input logic [4:0] d, input logic [2:0] l, input logic [63:0] data,
                    input int nwait, input rec_t x);
    mem_data = data;
    if (sel == 0) q_a.push_back(x); else q_b.push_back(x);
    send(sel, e, fn, d, l, 64'h0);
    repeat (nwait) tick();
    if (sel == 0) mem_valid_a = 1'b1; else mem_valid_b = 1'b1;
    tick();
    mem_valid_a = 1'b0;
    mem_valid_b = 1'b0;
    expect_next(sel, "load_record_after_mem_valid");
  endtask

  localparam logic [63:0] M = 64'hF1E2D3C4_B5A69788;

  initial begin
    rst_n = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; mem_valid_a = 1'b0; mem_valid_b = 1'b0;
    wb_ready = 1'b1; enc = '0; f3 = '0; dest = '0; lsb = '0; result = '0; mem_data = '0;

    @(negedge clk);
    chk("reset_a_outputs", 80'({a_wbv, a_flag, a_fp, a_exc, a_dest, a_value}), 80'(0));
    chk("reset_b_outputs", 80'({b_wbv, b_flag, b_fp, b_exc, b_dest, b_value}), 80'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 80'({a_ready, b_ready}), 80'(2'b11));
    tick();

    op(0, E_ARITH_REG, 3'b000, 5'd5, 3'b000, 64'h12345678, mk(1, 0, 0, 5'd5, 64'h12345678));

    mem_data = 64'h11223344_80667788;
    q_a.push_back(mk(1, 0, 0, 5'd7, 64'hFFFFFF80));
    send(0, E_LOAD, 3'b000, 5'd7, 3'b011, 64'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_valid_a = 1'b1;
      @(negedge clk);
      chk("lb_wait_ready_low", 80'(a_ready), 80'(0));
      tick();
    end
    mem_valid_a = 1'b0;
    expect_next(0, "lb_record_after_mem_valid");

    op(0, E_LOAD,      3'b001, 5'd9, 3'b001, 64'h0,        mk(0, 0, 1, 5'd9, 64'h0));
    op(0, E_ARITH_IMM, 3'b000, 5'd0, 3'b000, 64'hCAFE0001, mk(0, 0, 0, 5'd0, 64'hCAFE0001));
    op(0, E_LUI,       3'b000, 5'd1, 3'b000, 64'hABCDE000, mk(1, 0, 0, 5'd1, 64'hABCDE000));
    op(0, E_FARITH,    3'b000, 5'd0, 3'b000, 64'h40490FDB, mk(1, 1, 0, 5'd0, 64'h40490FDB));
    op(0, E_STORE,     3'b010, 5'd3, 3'b000, 64'h55,       mk(0, 0, 0, 5'd3, 64'h0));
    op(0, E_BRANCH,    3'b000, 5'd2, 3'b000, 64'h66,       mk(0, 0, 0, 5'd2, 64'h0));
    op(0, 16'h0003,    3'b000, 5'd4, 3'b000, 64'h77,       mk(0, 0, 0, 5'd4, 64'h0));

    ld(0, E_LOAD,  3'b100, 5'd10, 3'd5, M, 1, mk(1, 0, 0, 5'd10, 64'h000000D3));
    ld(0, E_LOAD,  3'b001, 5'd11, 3'd2, M, 0, mk(1, 0, 0, 5'd11, 64'hFFFFB5A6));
    ld(0, E_LOAD,  3'b101, 5'd12, 3'd6, M, 2, mk(1, 0, 0, 5'd12, 64'h0000F1E2));
    ld(0, E_LOAD,  3'b010, 5'd13, 3'd4, M, 0, mk(1, 0, 0, 5'd13, 64'hF1E2D3C4));
    ld(0, E_LOAD,  3'b000, 5'd14, 3'd0, M, 0, mk(1, 0, 0, 5'd14, 64'hFFFFFF88));
    ld(0, E_LOAD,  3'b000, 5'd0,  3'd1, M, 0, mk(0, 0, 0, 5'd0,  64'hFFFFFF97));
    ld(0, E_FLOAD, 3'b010, 5'd0,  3'd0, M, 0, mk(1, 1, 0, 5'd0,  64'hB5A69788));

    op(0, E_LOAD,  3'b011, 5'd15, 3'd0, 64'h0, mk(0, 0, 1, 5'd15, 64'h0));
    op(0, E_LOAD,  3'b110, 5'd16, 3'd4, 64'h0, mk(0, 0, 1, 5'd16, 64'h0));
    op(0, E_LOAD,  3'b111, 5'd17, 3'd0, 64'h0, mk(0, 0, 1, 5'd17, 64'h0));
    op(0, E_LOAD,  3'b010, 5'd18, 3'd2, 64'h0, mk(0, 0, 1, 5'd18, 64'h0));
    op(0, E_FLOAD, 3'b011, 5'd19, 3'd0, 64'h0, mk(0, 0, 1, 5'd19, 64'h0));
    op(0, E_FLOAD, 3'b010, 5'd20, 3'd2, 64'h0, mk(0, 0, 1, 5'd20, 64'h0));
    op(0, E_FLOAD, 3'b000, 5'd21, 3'd0, 64'h0, mk(0, 0, 1, 5'd21, 64'h0));

    // Stall: X held while wb_ready=0, Y accepted on the cycle wb_ready returns.
    wb_ready = 1'b0;
    q_a.push_back(mk(1, 0, 0, 5'd3, 64'h0000AAAA));
    send(0, E_ARITH_REG, 3'b000, 5'd3, 3'b000, 64'h0000AAAA);
    q_a.push_back(mk(1, 0, 0, 5'd4, 64'h0000BBBB));
    enc = E_ARITH_REG; f3 = 3'b000; dest = 5'd4; lsb = 3'b000; result = 64'h0000BBBB;
    valid_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_ready_low", 80'(a_ready), 80'(0));
      tick();
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 80'(a_ready), 80'(1));
    tick();
    valid_a = 1'b0;
    expect_next(0, "b2b_second_record");

    op(1, E_ARITH_REG, 3'b000, 5'd6, 3'b000, 64'h0123456789ABCDEF, mk(1, 0, 0, 5'd6, 64'h0123456789ABCDEF));
    ld(1, E_FLOAD, 3'b010, 5'd0,  3'd4, 64'h3F800000_DEADBEEF, 1, mk(1, 1, 0, 5'd0, 64'hFFFFFFFF3F800000));
    ld(1, E_LOAD,  3'b011, 5'd7,  3'd0, M, 0, mk(1, 0, 0, 5'd7,  64'hF1E2D3C4B5A69788));
    ld(1, E_LOAD,  3'b010, 5'd8,  3'd4, M, 0, mk(1, 0, 0, 5'd8,  64'hFFFFFFFFF1E2D3C4));
    ld(1, E_LOAD,  3'b110, 5'd9,  3'd4, M, 0, mk(1, 0, 0, 5'd9,  64'h00000000F1E2D3C4));
    ld(1, E_FLOAD, 3'b011, 5'd1,  3'd0, M, 0, mk(1, 1, 0, 5'd1,  64'hF1E2D3C4B5A69788));
    op(1, E_LOAD,  3'b011, 5'd10, 3'd4, 64'h0, mk(0, 0, 1, 5'd10, 64'h0));
    op(1, E_FMADD, 3'b000, 5'd0,  3'd0, 64'h400921FB54442D18, mk(1, 1, 0, 5'd0, 64'h400921FB54442D18));

    // Reset while A waits for memory; the late response must be dropped.
    mem_data = M;
    send(0, E_LOAD, 3'b010, 5'd22, 3'd0, 64'h0);
    @(negedge clk);
    chk("wait_mem_ready_low", 80'(a_ready), 80'(0));
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_a_outputs", 80'({a_wbv, a_flag, a_fp, a_exc, a_dest, a_value}), 80'(0));
    chk("midreset_a_idle", 80'(a_ready), 80'(1));
    tick();
    rst_n = 1'b1;
    mem_valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_valid_a = 1'b0;
      @(negedge clk);
      chk("post_reset_no_record", 80'(a_wbv), 80'(0));
      chk("post_reset_ready", 80'(a_ready), 80'(1));
      tick();
    end

    op(0, E_ARITH_REG, 3'b000, 5'd31, 3'b000, 64'h0F0F0F0F, mk(1, 0, 0, 5'd31, 64'h0F0F0F0F));

    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    chk("queues_drained", 80'(q_a.size() + q_b.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
